issue_select_encoder: RTL
=========================

Name: issue_select_encoder

Overview:
- Registered multi-grant select/encode stage for the issue queue.
- Takes a WIDTH-bit ready vector and picks up to NUM_GRANTS set bits in circular priority order, starting from a round-robin pointer.
- Outputs each pick as a binary index plus a valid bit, one cycle after acceptance, behind a valid/ready handshake.
- Replaces the single-result OR-encoder with a pipelined, fair, multi-issue selector.

Parameters:
- WIDTH, 32, ready-vector width (issue-queue entries); any value 2..64.
- WIDTH_LOG, 5, index width; must equal clog2(WIDTH).
- NUM_GRANTS, 2, max picks per cycle; 1..4, at most WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- flush_i  input  1  pipeline flush: drop the held result.
- req_valid_i  input  1  req_vec_i is valid.
- req_ready_o  output  1  stage can accept a request.
- req_vec_i  input  WIDTH  ready/request vector.
- out_valid_o  output  1  held result valid.
- out_ready_i  input  1  consumer accepts the held result.
- grant_valid_o  output  NUM_GRANTS  per-slot pick valid.
- grant_idx_o  output  NUM_GRANTS*WIDTH_LOG  per-slot index; slot k occupies bits [k*WIDTH_LOG +: WIDTH_LOG].
- grant_mask_o  output  WIDTH  one-hot OR of all valid picks, used for queue dequeue.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - out_valid_o=0, grant_valid_o=0, grant_idx_o=0, grant_mask_o=0, rr_ptr=0.
  - req_ready_o=1 from the first cycle after reset release.
- req_ready_o = !flush_i && (!out_valid_o || out_ready_i). This is combinational and provides single-register pass-through throughput.
- Accept = req_valid_i && req_ready_o.
- Selection, combinational on req_vec_i and rr_ptr:
  - Slot 0 takes the first set bit found scanning rr_ptr, rr_ptr+1, …, WIDTH-1, 0, …, rr_ptr-1.
  - Slot k takes the next set bit after slot k-1 in the same scan order.
  - Slots beyond the popcount are invalid; their index and valid bit are 0.
- On accept with popcount>0:
  - Next cycle: out_valid_o=1, with picks registered into grant_* (latency 1 cycle).
  - rr_ptr <= (last valid pick index + 1) mod WIDTH. Wrap goes from WIDTH-1 to 0, including for non-power-of-2 WIDTH.
- On accept with popcount=0:
  - Request is consumed.
  - out_valid_o <= 0 if out_ready_i, otherwise held.
  - rr_ptr unchanged.
- No accept:
  - If out_ready_i, out_valid_o <= 0.
  - Otherwise all outputs hold stable (valid must not drop without ready).
- flush_i=1:
  - Next cycle out_valid_o=0 and grant_valid_o=0. Indices and mask are zeroed.
  - No accept happens in the flush cycle (req_ready_o=0).
  - rr_ptr retained.
  - Flush has priority over accept and out_ready_i.
- Reset has priority over flush.
- grant_mask_o is always consistent with grant_valid_o/grant_idx_o. It is zero whenever out_valid_o=0.
- Picks within one result are distinct by construction.

Optional Feature:
- ISSUE_SEL_RR_EN:
  - Defined: round-robin pointer as above.
  - Undefined: rr_ptr is removed (constant 0). Fixed priority with the lowest index first; slots are filled in ascending index order with no wrap.

Decomposition:
- Package issue_sel_pkg:
  - ISSUE_WIDTH / ISSUE_WIDTH_LOG / ISSUE_NUM_GRANTS defaults.
  - Index typedef (logic [ISSUE_WIDTH_LOG-1:0]).
  - Function for modular pointer increment.
- Sub-module rr_find_first:
  - Inputs: vector, start pointer.
  - Outputs: found flag, index, one-hot.
  - Circular find-first, implemented as a doubled vector masked by the pointer.
- Instantiate it NUM_GRANTS times, chained. Each stage masks off the prior one-hot and uses the prior index+1 as its start.

Test Plan (defaults, ISSUE_SEL_RR_EN defined unless noted):
1. Hold rst_ni=0 for 3 cycles, then release → all outputs 0, rr_ptr=0; req_ready_o=1 the cycle after release.
2. rr_ptr=0, req_vec_i=0x0000_0012, out_ready_i=1 → next cycle:
   - out_valid_o=1, grant_valid_o=2'b11.
   - Slot0=1, slot1=4, grant_mask_o=0x12.
   - rr_ptr=5.
3. rr_ptr=5, req_vec_i=0x8000_0003 → slot0=31, slot1=0, grant_mask_o=0x8000_0001, rr_ptr=1.
   - With ISSUE_SEL_RR_EN undefined, the same vector gives slot0=0, slot1=1.
4. Backpressure: result held with out_ready_i=0 for 4 cycles while req_valid_i=1 →
   - req_ready_o=0 throughout; outputs unchanged.
   - Releasing out_ready_i accepts the pending request the same cycle, and the new result appears next cycle.
5. Sparse inputs:
   - req_vec_i=0 accepted → out_valid_o=0, rr_ptr unchanged.
   - Then req_vec_i=0x0000_0400 → grant_valid_o=2'b01, slot0=10, slot1 idx=0, rr_ptr=11.
6. flush_i=1 together with req_valid_i=1 while a result is held → next cycle out_valid_o=0, request not accepted, rr_ptr unchanged.
   - Reasserting the request after the flush yields the normal result.

Source files
------------

// File: rtl/issue_sel_pkg.sv
// Shared defaults, index type and pointer arithmetic for the issue select/encode stage.
package issue_sel_pkg;

  localparam int unsigned ISSUE_WIDTH      = 32;
  localparam int unsigned ISSUE_WIDTH_LOG  = 5;
  localparam int unsigned ISSUE_NUM_GRANTS = 2;

  typedef logic [ISSUE_WIDTH_LOG-1:0] issue_idx_t;

  // Wraps to 0 at width, so non-power-of-2 widths never reach an out-of-range index.
  function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Circular find-first-set starting at a pointer, using a doubled vector masked below the pointer.
module rr_find_first
  import issue_sel_pkg::*;
#(
  parameter int unsigned WIDTH     = ISSUE_WIDTH,
  parameter int unsigned WIDTH_LOG = ISSUE_WIDTH_LOG
) (
  input  logic [WIDTH-1:0]     vec,
  input  logic [WIDTH_LOG-1:0] start,
  output logic                 found,
  output logic [WIDTH_LOG-1:0] idx,
  output logic [WIDTH-1:0]     onehot
);

  logic [2*WIDTH-1:0] dbl;

  always_comb begin
    dbl    = {vec, vec};
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Upper copy supplies the wrapped-around positions below the pointer.
    for (int unsigned p = 0; p < 2 * WIDTH; p++) begin
      if (!found && dbl[p] && (p >= 32'(start))) begin
        found = 1'b1;
        idx   = WIDTH_LOG'(p % WIDTH);
      end
    end
    if (found) onehot = WIDTH'(1) << idx;
  end

endmodule

// File: rtl/issue_select_encoder.sv
// Registered multi-grant round-robin select/encode stage for the issue queue.
// Define ISSUE_SEL_RR_EN for round-robin priority; otherwise fixed lowest-index-first priority.
module issue_select_encoder
  import issue_sel_pkg::*;
#(
  parameter int unsigned WIDTH      = ISSUE_WIDTH,
  parameter int unsigned WIDTH_LOG  = ISSUE_WIDTH_LOG,
  parameter int unsigned NUM_GRANTS = ISSUE_NUM_GRANTS
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [WIDTH-1:0]                req_vec_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [NUM_GRANTS-1:0]           grant_valid_o,
  output logic [NUM_GRANTS*WIDTH_LOG-1:0] grant_idx_o,
  output logic [WIDTH-1:0]                grant_mask_o
);

  logic [WIDTH-1:0]     stage_vec   [NUM_GRANTS];
  logic [WIDTH_LOG-1:0] stage_start [NUM_GRANTS];
  logic [WIDTH_LOG-1:0] pick_idx    [NUM_GRANTS];
  logic [WIDTH-1:0]     pick_onehot [NUM_GRANTS];
  logic [NUM_GRANTS-1:0] pick_found;
  logic [WIDTH_LOG-1:0] rr_ptr;

  logic                            out_valid_q, out_valid_d;
  logic [NUM_GRANTS-1:0]           grant_valid_q, grant_valid_d;
  logic [NUM_GRANTS*WIDTH_LOG-1:0] grant_idx_q, grant_idx_d;
  logic [WIDTH-1:0]                grant_mask_q, grant_mask_d;
  logic                            accept;

`ifdef ISSUE_SEL_RR_EN
  logic [WIDTH_LOG-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // Each slot searches the vector minus earlier picks, starting just past the previous pick.
  for (genvar k = 0; k < NUM_GRANTS; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign stage_vec[k]   = req_vec_i;
      assign stage_start[k] = rr_ptr;
    end else begin : g_next
      assign stage_vec[k]   = stage_vec[k-1] & ~pick_onehot[k-1];
      assign stage_start[k] = WIDTH_LOG'(ptr_inc(32'(pick_idx[k-1]), WIDTH));
    end

    rr_find_first #(
      .WIDTH     (WIDTH),
      .WIDTH_LOG (WIDTH_LOG)
    ) u_find (
      .vec    (stage_vec[k]),
      .start  (stage_start[k]),
      .found  (pick_found[k]),
      .idx    (pick_idx[k]),
      .onehot (pick_onehot[k])
    );
  end

  assign req_ready_o = !flush_i && (!out_valid_q || out_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    out_valid_d   = out_valid_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_mask_d  = grant_mask_q;
`ifdef ISSUE_SEL_RR_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    if (flush_i || ((accept || out_ready_i) && !(accept && |pick_found))) begin
      out_valid_d   = 1'b0;
      grant_valid_d = '0;
      grant_idx_d   = '0;
      grant_mask_d  = '0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      grant_valid_d = pick_found;
      grant_mask_d  = '0;
      for (int unsigned k = 0; k < NUM_GRANTS; k++) begin
        grant_idx_d[k*WIDTH_LOG +: WIDTH_LOG] = pick_idx[k];
        grant_mask_d = grant_mask_d | pick_onehot[k];
`ifdef ISSUE_SEL_RR_EN
        if (pick_found[k]) rr_ptr_d = WIDTH_LOG'(ptr_inc(32'(pick_idx[k]), WIDTH));
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q   <= 1'b0;
      grant_valid_q <= '0;
      grant_idx_q   <= '0;
      grant_mask_q  <= '0;
`ifdef ISSUE_SEL_RR_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      out_valid_q   <= out_valid_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_mask_q  <= grant_mask_d;
`ifdef ISSUE_SEL_RR_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign out_valid_o   = out_valid_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_mask_o  = grant_mask_q;

endmodule
